// File: rtl/rw_issue_scheduler_pkg.sv
// Shared types for the read/write issue scheduler.
//   req_type_t    : kind of request held in the issue slot (read / write)
//   sched_state_t : arbitration priority state (RD_PRIO / WR_PRIO)
//   read_entries / write_entries : default outstanding-request limits
//   read_log / write_log         : credit counter widths for those limits
package types_def;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    RD_PRIO = 1'b0,
    WR_PRIO = 1'b1
  } sched_state_t;

  localparam int read_entries  = 16;
  localparam int write_entries = 16;
  localparam int read_log      = $clog2(read_entries) + 1;
  localparam int write_log     = $clog2(write_entries) + 1;

endpackage

// File: rtl/rw_issue_scheduler_credit_counter.sv
// Outstanding-request credit counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : one request admitted (never asserted while full)
//   dec      : one request completed
//   cnt      : number of outstanding requests, 0..ENTRIES
//   full     : cnt == ENTRIES
//   err      : sticky, set when a completion arrives with nothing outstanding
module credit_counter #(
  parameter int ENTRIES = 16,
  localparam int CW = $clog2(ENTRIES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          err
);

  assign full = (cnt == CW'(ENTRIES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (inc && !dec) begin
      // Saturate defensively; the grant logic never admits while full.
      if (!full) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) err <= 1'b1;
      else           cnt <= cnt - 1'b1;
    end
    // inc && dec together leave the count unchanged.
  end

endmodule

// File: rtl/rw_issue_scheduler.sv
// Read/write issue scheduler: arbitrates mapper read and write requests into
// a single registered issue slot, with per-type credit limits and a
// read-priority FSM that forces write bursts to avoid write starvation.
//   rd_req_* / wr_req_* : mapper request ports (ready = granted this cycle)
//   issue_*             : one-entry issue slot towards the back end
//   read_done/write_done: completions, each returns one credit
//   rd_full / wr_full   : credit limit reached
//   wr_prio             : FSM currently prefers writes
//   credit_err          : sticky completion-without-outstanding error
module rw_issue_scheduler
  import types_def::*;
#(
  parameter int RD_ENTRIES    = read_entries,
  parameter int WR_ENTRIES    = write_entries,
  parameter int MAX_RD_STREAK = 8,
  parameter int WR_BURST      = 4,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ready,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  output logic              wr_req_ready,
  output logic              issue_valid,
  output req_type_t         issue_type,
  output logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_ready,
  input  logic              read_done,
  input  logic              write_done,
  output logic              rd_full,
  output logic              wr_full,
  output logic              wr_prio,
  output logic              credit_err
);

  localparam int RCW = $clog2(RD_ENTRIES) + 1;
  localparam int WCW = $clog2(WR_ENTRIES) + 1;
  localparam int SW  = $clog2(MAX_RD_STREAK + 1);
  localparam int BW  = $clog2(WR_BURST + 1);

  sched_state_t   state;
  logic [SW-1:0]  streak;
  logic [BW-1:0]  burst;
  logic [RCW-1:0] rd_cnt;
  logic [WCW-1:0] wr_cnt;
  logic           rd_err;
  logic           wr_err;
  logic           slot_free;
  logic           rd_ok;
  logic           wr_ok;
  logic           rd_grant;
  logic           wr_grant;

  credit_counter #(.ENTRIES(RD_ENTRIES)) u_rd_credit (
    .clk  (clk),
    .rst  (rst),
    .inc  (rd_grant),
    .dec  (read_done),
    .cnt  (rd_cnt),
    .full (rd_full),
    .err  (rd_err)
  );

  credit_counter #(.ENTRIES(WR_ENTRIES)) u_wr_credit (
    .clk  (clk),
    .rst  (rst),
    .inc  (wr_grant),
    .dec  (write_done),
    .cnt  (wr_cnt),
    .full (wr_full),
    .err  (wr_err)
  );

  assign credit_err = rd_err | wr_err;
  assign wr_prio    = (state == WR_PRIO);

  // The slot can take a new request when empty or being drained this cycle.
  assign slot_free = !issue_valid || issue_ready;
  assign rd_ok     = rd_req_valid && !rd_full;
  assign wr_ok     = wr_req_valid && !wr_full;

  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (slot_free) begin
      if (state == RD_PRIO) begin
        if (rd_ok)      rd_grant = 1'b1;
        else if (wr_ok) wr_grant = 1'b1;
      end else begin
        if (wr_ok)      wr_grant = 1'b1;
        else if (rd_ok) rd_grant = 1'b1;
      end
    end
  end

  assign rd_req_ready = rd_grant;
  assign wr_req_ready = wr_grant;

  // Issue slot register: payload only changes on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_type  <= REQ_READ;
      issue_addr  <= '0;
    end else if (rd_grant) begin
      issue_valid <= 1'b1;
      issue_type  <= REQ_READ;
      issue_addr  <= rd_req_addr;
    end else if (wr_grant) begin
      issue_valid <= 1'b1;
      issue_type  <= REQ_WRITE;
      issue_addr  <= wr_req_addr;
    end else if (slot_free) begin
      issue_valid <= 1'b0;
    end
  end

  // Priority FSM. The streak only counts reads that bypassed a write that
  // could actually have been admitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RD_PRIO;
      streak <= '0;
      burst  <= '0;
    end else begin
      case (state)
        RD_PRIO: begin
          if (wr_grant || !wr_req_valid) begin
            streak <= '0;
          end else if (rd_grant && wr_ok) begin
            if (streak == SW'(MAX_RD_STREAK - 1)) begin
              state  <= WR_PRIO;
              streak <= '0;
              burst  <= '0;
            end else begin
              streak <= streak + 1'b1;
            end
          end
        end
        WR_PRIO: begin
          if (wr_grant) begin
            if (burst == BW'(WR_BURST - 1)) begin
              state  <= RD_PRIO;
              streak <= '0;
              burst  <= '0;
            end else begin
              burst <= burst + 1'b1;
            end
          end else if (!wr_ok && rd_ok) begin
            // No admissible write but reads waiting: stop holding reads off.
            state  <= RD_PRIO;
            streak <= '0;
            burst  <= '0;
          end
        end
        default: state <= RD_PRIO;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_issue_scheduler.sv
module tb_rw_issue_scheduler;
  import types_def::*;

  localparam int RDE = 16;
  localparam int WRE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_valid = 1'b0;
  logic [31:0] rd_req_addr  = '0;
  logic        rd_req_ready;
  logic        wr_req_valid = 1'b0;
  logic [31:0] wr_req_addr  = '0;
  logic        wr_req_ready;
  logic        issue_valid;
  req_type_t   issue_type;
  logic [31:0] issue_addr;
  logic        issue_ready = 1'b0;
  logic        read_done   = 1'b0;
  logic        write_done  = 1'b0;
  logic        rd_full;
  logic        wr_full;
  logic        wr_prio;
  logic        credit_err;

  rw_issue_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_ready (rd_req_ready),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_ready (wr_req_ready),
    .issue_valid  (issue_valid),
    .issue_type   (issue_type),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .read_done    (read_done),
    .write_done   (write_done),
    .rd_full      (rd_full),
    .wr_full      (wr_full),
    .wr_prio      (wr_prio),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding counts, priority mode, slot contents.
  int          m_rd, m_wr, m_streak, m_burst;
  bit          m_wprio, m_err, m_valid, m_is_wr;
  logic [31:0] m_addr;
  bit          g_r, g_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_streak = 0; m_burst = 0;
    m_wprio = 0; m_err = 0; m_valid = 0; m_is_wr = 0; m_addr = '0;
  endtask

  // One clock cycle: inputs are already driven (just after a negedge).
  task automatic step();
    bit sf, rok, wok;
    #1;
    sf  = !m_valid || issue_ready;
    rok = rd_req_valid && (m_rd < RDE);
    wok = wr_req_valid && (m_wr < WRE);
    g_r = 0; g_w = 0;
    if (sf) begin
      if (m_wprio) begin g_w = wok; g_r = !wok && rok; end
      else         begin g_r = rok; g_w = !rok && wok; end
    end
    check("rd_req_ready", 32'(rd_req_ready), 32'(g_r));
    check("wr_req_ready", 32'(wr_req_ready), 32'(g_w));
    @(posedge clk);
    // credits
    if (read_done && !g_r && m_rd == 0) m_err = 1;
    else m_rd = m_rd + int'(g_r) - int'(read_done);
    if (write_done && !g_w && m_wr == 0) m_err = 1;
    else m_wr = m_wr + int'(g_w) - int'(write_done);
    // priority rules
    if (!m_wprio) begin
      if (g_w || !wr_req_valid) m_streak = 0;
      else if (g_r && wok) begin
        m_streak++;
        if (m_streak == 8) begin m_wprio = 1; m_burst = 0; m_streak = 0; end
      end
    end else begin
      if (g_w) begin
        m_burst++;
        if (m_burst == 4) begin m_wprio = 0; m_streak = 0; m_burst = 0; end
      end else if (!wok && rok) begin
        m_wprio = 0; m_streak = 0; m_burst = 0;
      end
    end
    // slot
    if (g_r)      begin m_valid = 1; m_is_wr = 0; m_addr = rd_req_addr; end
    else if (g_w) begin m_valid = 1; m_is_wr = 1; m_addr = wr_req_addr; end
    else if (sf)  m_valid = 0;
    @(negedge clk);
    check("issue_valid", 32'(issue_valid), 32'(m_valid));
    if (m_valid) begin
      check("issue_type", 32'(issue_type), 32'(m_is_wr));
      check("issue_addr", issue_addr, m_addr);
    end
    check("rd_full", 32'(rd_full), 32'(m_rd == RDE));
    check("wr_full", 32'(wr_full), 32'(m_wr == WRE));
    check("wr_prio", 32'(wr_prio), 32'(m_wprio));
    check("credit_err", 32'(credit_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    rd_req_valid = 0; wr_req_valid = 0; read_done = 0; write_done = 0;
  endtask

  task automatic drain();
    int guard = 0;
    idle_inputs();
    while ((m_rd > 0 || m_wr > 0) && guard < 100) begin
      read_done  = (m_rd > 0);
      write_done = (m_wr > 0);
      step();
      guard++;
    end
    idle_inputs();
    check("drain_bound", 32'(guard < 100), 32'd1);
  endtask

  logic [31:0] held;
  int          ngr;

  initial begin
    model_reset();
    // 1. reset state
    @(negedge clk); @(negedge clk);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_addr", issue_addr, 32'd0);
    check("rst_issue_type", 32'(issue_type), 32'd0);
    check("rst_flags", {28'd0, rd_full, wr_full, wr_prio, credit_err}, 32'd0);
    check("rst_ready", {30'd0, rd_req_ready, wr_req_ready}, 32'd0);
    rst = 0;
    issue_ready = 1;
    repeat (3) step();

    // 2. 17 reads, no completions: 16 admitted, 17th held until a credit returns
    rd_req_valid = 1;
    ngr = 0;
    for (int i = 0; i < 17; i++) begin
      rd_req_addr = 32'h1000 + 32'(i);
      step();
      ngr += int'(g_r);
    end
    check("t2_grants", 32'(ngr), 32'd16);
    check("t2_rd_full", 32'(rd_full), 32'd1);
    #1 check("t2_held_ready", 32'(rd_req_ready), 32'd0);
    read_done = 1;
    step();
    read_done = 0;
    step();
    check("t2_17th_issued", issue_addr, 32'h1010);
    drain();

    // 3. both valid continuously: 8 R, 4 W, 8 R, 4 W
    rd_req_valid = 1; wr_req_valid = 1;
    for (int i = 0; i < 24; i++) begin
      bit exp_w;
      exp_w = (i % 12) >= 8;
      rd_req_addr = 32'h2000 + 32'(i);
      wr_req_addr = 32'h3000 + 32'(i);
      step();
      check("t3_order_w", 32'(g_w), 32'(exp_w));
      check("t3_order_r", 32'(g_r), 32'(!exp_w));
    end
    drain();

    // 4. grant + done same cycle at count 5; write_done at 0
    rd_req_valid = 1;
    for (int i = 0; i < 5; i++) begin rd_req_addr = 32'h4000 + 32'(i); step(); end
    read_done = 1; rd_req_addr = 32'h4005;
    step();
    check("t4_rd_cnt", 32'(dut.rd_cnt), 32'd5);
    idle_inputs();
    write_done = 1;
    step();
    write_done = 0;
    check("t4_credit_err", 32'(credit_err), 32'd1);
    check("t4_wr_cnt", 32'(dut.wr_cnt), 32'd0);

    // 5. back-pressure: payload stable, then reload with valid kept high
    issue_ready = 0; rd_req_valid = 1; rd_req_addr = 32'h5000;
    step();
    held = issue_addr;
    for (int i = 0; i < 3; i++) begin
      rd_req_addr = 32'h5001 + 32'(i);
      step();
      check("t5_no_grant", 32'(g_r | g_w), 32'd0);
      check("t5_addr_stable", issue_addr, held);
    end
    issue_ready = 1;
    step();
    check("t5_reload_valid", 32'(issue_valid), 32'd1);
    check("t5_reload_addr", issue_addr, 32'h5003);

    // 6. async reset with rd_cnt=7 and slot full
    issue_ready = 0; rd_req_valid = 0;
    step();
    check("t6_pre_cnt", 32'(dut.rd_cnt), 32'd7);
    #2 rst = 1;
    #1;
    check("t6_async_valid", 32'(issue_valid), 32'd0);
    check("t6_async_cnt", 32'(dut.rd_cnt), 32'd0);
    check("t6_async_prio", 32'(wr_prio), 32'd0);
    check("t6_async_err", 32'(credit_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit wr_quiet;
      wr_quiet     = ((i / 100) % 4) == 3;
      rd_req_valid = ($urandom_range(0, 3) != 0);
      wr_req_valid = !wr_quiet && ($urandom_range(0, 2) != 0);
      rd_req_addr  = $urandom;
      wr_req_addr  = $urandom;
      issue_ready  = ($urandom_range(0, 3) != 0);
      read_done    = (m_rd > 0) && ($urandom_range(0, 2) == 0);
      write_done   = (m_wr > 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    // completion after a reset is a credit error
    idle_inputs();
    #2 rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
    read_done = 1;
    step();
    read_done = 0;
    step();
    check("post_rst_err", 32'(credit_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
